// File: rtl/ssg_pkg.sv
// ==== ssg_pkg : shared widths, PWM period and mix helper for the output path ====
// ==== rev 1.0 ====
`default_nettype none

package ssg_pkg;

  localparam int CH_WIDTH   = 6;
  localparam int NUM_CH     = 4;
  localparam int MIX_WIDTH  = CH_WIDTH + $clog2(NUM_CH);
  localparam int PWM_PERIOD = 256;

  typedef logic [MIX_WIDTH-1:0] mix_t;

  // Widening to MIX_WIDTH before adding keeps the carry; 4 x 63 = 252 fits without saturation.
  function automatic mix_t mix_attenuate(input logic [CH_WIDTH-1:0] c0,
                                         input logic [CH_WIDTH-1:0] c1,
                                         input logic [CH_WIDTH-1:0] c2,
                                         input logic [CH_WIDTH-1:0] c3,
                                         input logic [2:0]          vol);
    mix_t sum;
    sum = mix_t'(c0) + mix_t'(c1) + mix_t'(c2) + mix_t'(c3);
    return sum >> vol;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssg_pwm_core.sv
// ==== ssg_pwm_core : free-running 256-cycle PWM counter, compare and period pulse ====
// ==== rev 1.0 ====
`default_nettype none

module ssg_pwm_core
  import ssg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic [MIX_WIDTH-1:0] duty_i,
  output logic                 boundary_o,
  output logic                 pwm_o,
  output logic                 period_start_o
);

  logic [MIX_WIDTH-1:0] cnt_q;
  logic [MIX_WIDTH-1:0] cnt_d;
  logic                 run_q;
  logic                 pwm_q;
  logic                 period_start_q;

  // A period begins on a wrap or on the first enabled edge after a stop.
  assign boundary_o = enable_i && (!run_q || (cnt_q == MIX_WIDTH'(PWM_PERIOD - 1)));

  always_comb begin
    cnt_d = '0;
    if (enable_i && !boundary_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // duty_i is the duty in force for the cycle being registered, so a newly
  // loaded level already shapes the first cycle of its period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      run_q          <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      run_q          <= enable_i;
      pwm_q          <= enable_i && (cnt_d < duty_i);
      period_start_q <= boundary_o;
    end
  end

  assign pwm_o          = pwm_q;
  assign period_start_o = period_start_q;

endmodule

`default_nettype wire

// File: rtl/ssg_mix_pwm.sv
// ==== ssg_mix_pwm : four-channel mix, one-deep pending buffer and PWM playout ====
// ==== rev 1.0 ====
`default_nettype none

module ssg_mix_pwm
  import ssg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH_WIDTH-1:0]  channel0_i,
  input  logic [CH_WIDTH-1:0]  channel1_i,
  input  logic [CH_WIDTH-1:0]  channel2_i,
  input  logic [CH_WIDTH-1:0]  channel3_i,
  input  logic [2:0]           volume_i,
  input  logic                 sample_valid_i,
  output logic                 sample_ready_o,
  input  logic                 enable_i,
  output logic                 pwm_o,
  output logic [MIX_WIDTH-1:0] mix_level_o,
  output logic                 period_start_o,
  output logic                 underrun_o
);

  logic [MIX_WIDTH-1:0] pending_q;
  logic [MIX_WIDTH-1:0] pending_d;
  logic [MIX_WIDTH-1:0] duty_q;
  logic [MIX_WIDTH-1:0] duty_d;
  logic                 pending_full_q;
  logic                 pending_full_d;
  logic                 ready_q;
  logic                 underrun_q;
  logic                 accept;
  logic                 boundary;
  logic                 load;

  // ready_q only rises when the buffer is empty, so accept and load never coincide.
  assign accept = sample_valid_i && ready_q;
  assign load   = boundary && pending_full_q;

  always_comb begin
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    duty_d         = duty_q;
    if (load) begin
      duty_d         = pending_q;
      pending_full_d = 1'b0;
    end
    if (accept) begin
      pending_d      = mix_attenuate(channel0_i, channel1_i, channel2_i, channel3_i, volume_i);
      pending_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      duty_q         <= '0;
      ready_q        <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      duty_q         <= duty_d;
      ready_q        <= !pending_full_d;
      underrun_q     <= boundary && !pending_full_q;
    end
  end

  ssg_pwm_core u_core (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable_i       (enable_i),
    .duty_i         (duty_d),
    .boundary_o     (boundary),
    .pwm_o          (pwm_o),
    .period_start_o (period_start_o)
  );

  assign sample_ready_o = ready_q;
  assign mix_level_o    = duty_q;
  assign underrun_o     = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_ssg_mix_pwm.sv
// ==== tb_ssg_mix_pwm : scoreboard bench for ssg_mix_pwm ====
// ==== rev 1.0 ====
`timescale 1ns/1ps
`default_nettype none

module tb_ssg_mix_pwm;
  import ssg_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [CH_WIDTH-1:0]  ch0 = '0;
  logic [CH_WIDTH-1:0]  ch1 = '0;
  logic [CH_WIDTH-1:0]  ch2 = '0;
  logic [CH_WIDTH-1:0]  ch3 = '0;
  logic [2:0]           vol = '0;
  logic                 valid = 1'b0;
  logic                 enable = 1'b0;
  logic                 sample_ready;
  logic                 pwm;
  logic [MIX_WIDTH-1:0] mix_level;
  logic                 period_start;
  logic                 underrun;

  ssg_mix_pwm dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .channel0_i     (ch0),
    .channel1_i     (ch1),
    .channel2_i     (ch2),
    .channel3_i     (ch3),
    .volume_i       (vol),
    .sample_valid_i (valid),
    .sample_ready_o (sample_ready),
    .enable_i       (enable),
    .pwm_o          (pwm),
    .mix_level_o    (mix_level),
    .period_start_o (period_start),
    .underrun_o     (underrun)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int          mix;
    int unsigned acc_edge;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each period start pops the next accepted level (accepted strictly before
  // the boundary edge) or expects an underrun; each full period checks PWM shape.
  int cur_duty = 0;
  int hi_cnt   = 0;
  int cyc_cnt  = 0;
  int exp_duty;
  int exp_ur;
  bit active   = 0;
  bit trunc    = 0;
  bit shape_ok = 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_duty = 0;
      active   = 0;
      trunc    = 0;
    end else begin
      if (underrun && !period_start) chk("underrun_without_period_start", 1, 0);
      if (period_start) begin
        if (active && !trunc) begin
          chk("period_length", cyc_cnt, PWM_PERIOD);
          chk("pwm_high_cycles", hi_cnt, cur_duty);
          chk("pwm_shape_ok", int'(shape_ok), 1);
        end
        exp_duty = cur_duty;
        exp_ur   = 1;
        if (sb_q.size() > 0 && sb_q[0].acc_edge < edge_n) begin
          exp_duty = sb_q[0].mix;
          exp_ur   = 0;
          void'(sb_q.pop_front());
        end
        chk("mix_level", int'(mix_level), exp_duty);
        chk("underrun", int'(underrun), exp_ur);
        cur_duty = exp_duty;
        active   = 1;
        trunc    = 0;
        hi_cnt   = 0;
        cyc_cnt  = 0;
        shape_ok = 1;
      end
      if (active) begin
        if (!trunc) begin
          if (pwm) hi_cnt++;
          if (pwm != (cyc_cnt < cur_duty)) shape_ok = 0;
          cyc_cnt++;
        end
        if (!enable) trunc = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a sample set and hold it until the handshake completes.
  task automatic send(input int c0, input int c1, input int c2, input int c3,
                      input int v, input int exp_mix, input string name);
    bit done = 0;
    ch0   = CH_WIDTH'(c0);
    ch1   = CH_WIDTH'(c1);
    ch2   = CH_WIDTH'(c2);
    ch3   = CH_WIDTH'(c3);
    vol   = 3'(v);
    valid = 1'b1;
    for (int k = 0; k < 700 && !done; k++) begin
      @(negedge clk);
      if (sample_ready) begin
        @(posedge clk);
        #1;
        sb_q.push_back('{exp_mix, edge_n});
        done = 1;
      end
    end
    valid = 1'b0;
    if (!done) chk({name, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_ps(input string name);
    bit seen = 0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (period_start) seen = 1;
    end
    if (!seen) chk({name, "_period_timeout"}, 0, 1);
    tick(1);
  endtask

  int hits;

  initial begin
    // Reset state
    tick(3);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_mix_level", int'(mix_level), 0);
    chk("reset_ready", int'(sample_ready), 0);
    chk("reset_period_start", int'(period_start), 0);
    chk("reset_underrun", int'(underrun), 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", int'(sample_ready), 0);
    tick(1);
    chk("ready_after_first_edge", int'(sample_ready), 1);

    // Idle with no samples: pin stays low, underrun each period
    hits = 0;
    for (int k = 0; k < 3 * PWM_PERIOD; k++) begin
      @(negedge clk);
      if (pwm) hits++;
    end
    chk("idle_pwm_high_cycles", hits, 0);
    tick(1);

    // Full scale and attenuated mixes
    send(63, 63, 63, 63, 0, 252, "full_scale");
    wait_ps("full_scale_load");
    wait_ps("full_scale_end");
    send(10, 20, 30, 5, 2, 16, "shift2");
    wait_ps("shift2_load");
    wait_ps("shift2_end");

    // Back-to-back 40, 80, 120 with valid held
    chk("ready_before_burst", int'(sample_ready), 1);
    send(10, 10, 10, 10, 0, 40, "burst40");
    send(40, 40, 40, 40, 1, 80, "burst80");
    send(60, 60, 60, 60, 1, 120, "burst120");
    wait_ps("burst120_load");

    // Enable dropped mid-period while 120 plays
    tick(100);
    chk("pwm_high_before_disable", int'(pwm), 1);
    enable = 1'b0;
    tick(1);
    chk("pwm_low_after_disable", int'(pwm), 0);
    send(7, 8, 9, 10, 0, 34, "buffered_a");
    ch0 = 6'd40; ch1 = 6'd41; ch2 = 6'd42; ch3 = 6'd43; vol = 3'd0;
    valid = 1'b1;
    hits = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (sample_ready || period_start || pwm) hits++;
    end
    chk("disabled_stall_activity", hits, 0);
    tick(1);
    enable = 1'b1;
    send(40, 41, 42, 43, 0, 166, "buffered_b");
    wait_ps("buffered_b_load");

    // Reset mid-period with a sample pending
    tick(50);
    send(50, 50, 50, 50, 0, 200, "discarded");
    tick(20);
    chk("pwm_high_before_reset", int'(pwm), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async_pwm", int'(pwm), 0);
    chk("reset_async_mix_level", int'(mix_level), 0);
    sb_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("ready_after_rerelease", int'(sample_ready), 1);
    chk("mix_level_after_rerelease", int'(mix_level), 0);
    wait_ps("post_reset_1");
    wait_ps("post_reset_2");

    chk("scoreboard_drained", int'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
